// File: rtl/bp_update_scheduler.sv
// In-flight branch tracker: in-order tags, out-of-order resolve, in-order predictor update with mispredict squash.
// Optional BPSCHED_STATS_EN adds retired/mispredict counters.
module bp_update_scheduler #(
   parameter  int DEPTH     = 8,
   parameter  int GHR_WIDTH = 8,
   localparam int TAG_W     = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alloc_valid,
   output logic                 alloc_ready,
   input  logic [31:0]          alloc_pc,
   input  logic                 alloc_pred,
   input  logic [GHR_WIDTH-1:0] alloc_ghr,
   output logic [TAG_W-1:0]     alloc_tag,
   input  logic                 res_valid,
   input  logic [TAG_W-1:0]     res_tag,
   input  logic                 res_taken,
   output logic                 upd_valid,
   output logic [31:0]          upd_pc,
   output logic                 upd_taken,
   output logic                 recover,
   output logic [GHR_WIDTH-1:0] recover_ghr,
`ifdef BPSCHED_STATS_EN
   output logic [31:0]          stat_retired,
   output logic [31:0]          stat_mispred,
`endif
   output logic [TAG_W:0]       occupancy
);

   typedef enum logic {RUN, RECOVER} state_t;

   localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

   state_t                 state;
   logic [TAG_W:0]         head, tail;
   logic [DEPTH-1:0]       ent_valid, ent_resolved, ent_taken, ent_pred;
   logic [31:0]            ent_pc  [DEPTH];
   logic [GHR_WIDTH-1:0]   ent_ghr [DEPTH];

   logic [TAG_W-1:0]       head_idx, tail_idx;
   logic                   full, retire, mispredict, alloc_fire, res_hit;

   assign head_idx    = head[TAG_W-1:0];
   assign tail_idx    = tail[TAG_W-1:0];
   assign full        = (head[TAG_W] != tail[TAG_W]) && (head_idx == tail_idx);
   assign occupancy   = tail - head;
   assign alloc_tag   = tail_idx;
   assign alloc_ready = !full && (state == RUN);
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign res_hit     = (state == RUN) && res_valid && ent_valid[res_tag];
   assign retire      = (state == RUN) && ent_valid[head_idx] && ent_resolved[head_idx];
   assign mispredict  = retire && (ent_taken[head_idx] != ent_pred[head_idx]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= RUN;
         head         <= '0;
         tail         <= '0;
         ent_valid    <= '0;
         ent_resolved <= '0;
         upd_valid    <= 1'b0;
         upd_pc       <= '0;
         upd_taken    <= 1'b0;
         recover      <= 1'b0;
         recover_ghr  <= '0;
      end else begin
         upd_valid <= retire;
         recover   <= mispredict;
         if (retire) begin
            upd_pc    <= ent_pc[head_idx];
            upd_taken <= ent_taken[head_idx];
         end
         if (mispredict)
            recover_ghr <= {ent_ghr[head_idx][GHR_WIDTH-2:0], ent_taken[head_idx]};

         case (state)
            RUN:     if (mispredict) state <= RECOVER;
            RECOVER: state <= RUN;
            default: state <= RUN;
         endcase

         if (res_hit)
            ent_resolved[res_tag] <= 1'b1;
         if (retire) begin
            ent_valid[head_idx]    <= 1'b0;
            ent_resolved[head_idx] <= 1'b0;
            head                   <= head + PTR_ONE;
         end
         // A branch allocated on the mispredict edge is younger than it and is dropped.
         if (alloc_fire && !mispredict) begin
            ent_valid[tail_idx]    <= 1'b1;
            ent_resolved[tail_idx] <= 1'b0;
            tail                   <= tail + PTR_ONE;
         end
         if (mispredict) begin
            ent_valid    <= '0;
            ent_resolved <= '0;
            tail         <= head + PTR_ONE;
         end
      end
   end

   // Payload storage carries no reset; the valid bits qualify it.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         ent_pc[tail_idx]   <= alloc_pc;
         ent_pred[tail_idx] <= alloc_pred;
         ent_ghr[tail_idx]  <= alloc_ghr;
      end
      if (res_hit)
         ent_taken[res_tag] <= res_taken;
   end

`ifdef BPSCHED_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_retired <= '0;
         stat_mispred <= '0;
      end else begin
         if (upd_valid) stat_retired <= stat_retired + 32'd1;
         if (recover)   stat_mispred <= stat_mispred + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: directed scenarios plus random traffic against a queue-based reference model.
module tb_bp_update_scheduler;
   localparam int DEPTH = 8;
   localparam int GW    = 8;
   localparam int TW    = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          alloc_valid = 1'b0, alloc_pred = 1'b0;
   logic [31:0]   alloc_pc = '0;
   logic [GW-1:0] alloc_ghr = '0;
   logic          res_valid = 1'b0, res_taken = 1'b0;
   logic [TW-1:0] res_tag = '0;
   logic          alloc_ready, upd_valid, upd_taken, recover;
   logic [TW-1:0] alloc_tag;
   logic [31:0]   upd_pc;
   logic [GW-1:0] recover_ghr;
   logic [TW:0]   occupancy;
`ifdef BPSCHED_STATS_EN
   logic [31:0]   stat_retired, stat_mispred;
`endif

   bp_update_scheduler #(.DEPTH(DEPTH), .GHR_WIDTH(GW)) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
      .alloc_pred(alloc_pred), .alloc_ghr(alloc_ghr), .alloc_tag(alloc_tag),
      .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .recover(recover), .recover_ghr(recover_ghr),
`ifdef BPSCHED_STATS_EN
      .stat_retired(stat_retired), .stat_mispred(stat_mispred),
`endif
      .occupancy(occupancy));

   always #5 clk = ~clk;

   typedef struct {
      int          tag;
      logic [31:0] pc;
      bit          pred;
      logic [GW-1:0] ghr;
      bit          resolved;
      bit          taken;
   } ent_t;

   // Reference model: in-flight branches in program order
   ent_t          q[$];
   int            next_tag;
   bit            m_recov;
   bit            e_upd, e_utaken, e_rec;
   logic [31:0]   e_upc;
   logic [GW-1:0] e_rghr;
   int            e_sret, e_smis;
   int            n_chk = 0, n_err = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      next_tag = 0; m_recov = 0;
      e_upd = 0; e_utaken = 0; e_rec = 0; e_upc = '0; e_rghr = '0;
      e_sret = 0; e_smis = 0;
   endtask

   // Starts and ends at a falling edge: checks outputs, drives inputs, advances the model one clock.
   task automatic cycle(input bit av, input logic [31:0] pc, input bit pred, input logic [GW-1:0] ghr,
                        input bit rv, input int rtag, input bit rtaken);
      bit ready, ret, mis;
      int ret_tag;
      ready = (q.size() < DEPTH) && !m_recov;
      chk_eq("upd_valid", upd_valid, e_upd);
      if (e_upd) begin
         chk_eq("upd_pc", upd_pc, e_upc);
         chk_eq("upd_taken", upd_taken, e_utaken);
      end
      chk_eq("recover", recover, e_rec);
      if (e_rec) chk_eq("recover_ghr", recover_ghr, e_rghr);
      chk_eq("occupancy", occupancy, q.size());
      chk_eq("alloc_ready", alloc_ready, ready);
      chk_eq("alloc_tag", alloc_tag, next_tag);
`ifdef BPSCHED_STATS_EN
      chk_eq("stat_retired", stat_retired, e_sret);
      chk_eq("stat_mispred", stat_mispred, e_smis);
`endif
      alloc_valid = av; alloc_pc = pc; alloc_pred = pred; alloc_ghr = ghr;
      res_valid = rv; res_tag = rtag[TW-1:0]; res_taken = rtaken;

      ret = !m_recov && q.size() > 0 && q[0].resolved;
      mis = ret && (q[0].taken != q[0].pred);
      ret_tag = ret ? q[0].tag : 0;
      e_sret += int'(e_upd);
      e_smis += int'(e_rec);
      e_upd = ret; e_rec = mis;
      if (ret) begin
         e_upc = q[0].pc;
         e_utaken = q[0].taken;
      end
      if (mis) e_rghr = {q[0].ghr[GW-2:0], q[0].taken};
      if (!m_recov && rv)
         foreach (q[i]) if (q[i].tag == rtag) begin
            q[i].resolved = 1;
            q[i].taken = rtaken;
         end
      if (ret) void'(q.pop_front());
      if (av && ready && !mis) begin
         q.push_back('{next_tag, pc, pred, ghr, 1'b0, 1'b0});
         next_tag = (next_tag + 1) % DEPTH;
      end
      if (mis) begin
         q.delete();
         next_tag = (ret_tag + 1) % DEPTH;
      end
      m_recov = mis;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      alloc_valid = 0; res_valid = 0;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int rt;
      bit ap, tk;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // T1 reset state
      chk_eq("t1_ready", alloc_ready, 1);
      chk_eq("t1_occ", occupancy, 0);
      chk_eq("t1_upd", upd_valid, 0);
      chk_eq("t1_recover", recover, 0);
      chk_eq("t1_upd_pc", upd_pc, 0);

      // T2 out-of-order resolve, in-order retire
      cycle(1, 32'h100, 0, 8'h11, 0, 0, 0);
      cycle(1, 32'h104, 1, 8'h22, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 1, 1);
      cycle(0, 0, 0, 0, 1, 0, 0);
      chk_eq("t2_no_early_upd", upd_valid, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk_eq("t2_upd0_pc", upd_pc, 32'h100);
      chk_eq("t2_upd0_tk", upd_taken, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk_eq("t2_upd1_pc", upd_pc, 32'h104);
      chk_eq("t2_upd1_tk", upd_taken, 1);
      idle(2);
`ifdef BPSCHED_STATS_EN
      chk_eq("t2_stat_ret", stat_retired, 2);
`endif

      // T3 full and tag wrap
      do_reset();
      for (int i = 0; i < DEPTH; i++) cycle(1, 32'h200 + 4 * i, 0, 8'(i), 0, 0, 0);
      chk_eq("t3_occ_full", occupancy, DEPTH);
      chk_eq("t3_ready_full", alloc_ready, 0);
      cycle(1, 32'hDEAD, 1, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk_eq("t3_wrap_tag", alloc_tag, 0);
      chk_eq("t3_occ", occupancy, DEPTH - 1);
      cycle(1, 32'h300, 1, 0, 0, 0, 0);
      idle(2);

      // T4 mispredict squash
      do_reset();
      cycle(1, 32'h400, 0, 8'h5A, 0, 0, 0);
      for (int i = 1; i < 4; i++) cycle(1, 32'h400 + 4 * i, 1, 8'h00, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk_eq("t4_upd", upd_valid, 1);
      chk_eq("t4_upd_tk", upd_taken, 1);
      chk_eq("t4_recover", recover, 1);
      chk_eq("t4_rghr", recover_ghr, 8'hB5);
      chk_eq("t4_occ", occupancy, 0);
      cycle(1, 32'h500, 0, 0, 1, 2, 1);
      cycle(0, 0, 0, 0, 1, 2, 1);
      idle(3);
      chk_eq("t4_late_upd", upd_valid, 0);
`ifdef BPSCHED_STATS_EN
      chk_eq("t4_stat_mis", stat_mispred, 1);
`endif

      // T5 stale resolve on empty queue
      do_reset();
      cycle(0, 0, 0, 0, 1, 5, 1);
      idle(3);
      chk_eq("t5_occ", occupancy, 0);
      chk_eq("t5_upd", upd_valid, 0);

      // T6 reset with live entries
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1, 32'h600 + 4 * i, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 1, 0);
      cycle(0, 0, 0, 0, 1, 2, 0);
      reset = 1'b1;
      res_valid = 1'b1; res_tag = 0; res_taken = 0;
      @(negedge clk);
      chk_eq("t6_upd_in_reset", upd_valid, 0);
      chk_eq("t6_rec_in_reset", recover, 0);
      reset = 1'b0; res_valid = 1'b0;
      model_reset();
      @(negedge clk);
      chk_eq("t6_occ", occupancy, 0);
      chk_eq("t6_upd", upd_valid, 0);
      idle(2);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         ap = 1'($urandom_range(0, 1));
         if (q.size() > 0 && $urandom_range(0, 9) < 7) begin
            int k;
            k = $urandom_range(0, q.size() - 1);
            rt = q[k].tag;
            tk = ($urandom_range(0, 99) < 85) ? q[k].pred : !q[k].pred;
         end else begin
            rt = $urandom_range(0, DEPTH - 1);
            tk = 1'($urandom_range(0, 1));
         end
         cycle($urandom_range(0, 9) < 6, $urandom, ap, 8'($urandom),
               $urandom_range(0, 1) == 1, rt, tk);
      end
      idle(DEPTH + 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
